// File: rtl/traf_phase_ctrl_pkg.sv
// traf_pkg: shared types and default timing for the traffic phase controller.
//   state_e   : controller state (GREEN, YELLOW, ALL_RED)
//   *_DEF     : default parameter values, in ticks where timing-related
//   TCNT_W    : width of the in-state tick counter
// Optional feature macro: TRAF_PED_EN (pedestrian walk), see traf_phase_ctrl.
package traf_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } state_e;

    localparam int NUM_PHASES_DEF = 4;
    localparam int GREEN_MIN_DEF  = 5;
    localparam int GREEN_MAX_DEF  = 20;
    localparam int YELLOW_T_DEF   = 3;
    localparam int ALL_RED_T_DEF  = 1;
    localparam int WALK_T_DEF     = 4;

    // Wide enough for any sensible GREEN_MAX; counter saturates in GREEN.
    localparam int TCNT_W = 16;

endpackage

// File: rtl/traf_phase_ctrl_if.sv
// traf_phase_ctrl_if: controller I/O bundle (clock and reset stay scalar ports).
//   tick    : timebase enable            (master -> slave)
//   sense   : per-phase detectors        (master -> slave)
//   red/yellow/green : lamp drives       (slave -> master)
//   phase   : phase being served         (slave -> master)
//   pending : latched demand             (slave -> master)
//   ped_req / walk : only with TRAF_PED_EN defined
interface traf_phase_ctrl_if #(
    parameter int NUM_PHASES = 4
);
    localparam int PW = $clog2(NUM_PHASES);

    logic                  tick;
    logic [NUM_PHASES-1:0] sense;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] green;
    logic [PW-1:0]         phase;
    logic [NUM_PHASES-1:0] pending;
`ifdef TRAF_PED_EN
    logic [NUM_PHASES-1:0] ped_req;
    logic [NUM_PHASES-1:0] walk;
`endif

    modport master (
`ifdef TRAF_PED_EN
        output ped_req,
        input  walk,
`endif
        output tick, sense,
        input  red, yellow, green, phase, pending
    );

    modport slave (
`ifdef TRAF_PED_EN
        input  ped_req,
        output walk,
`endif
        input  tick, sense,
        output red, yellow, green, phase, pending
    );

endinterface

// File: rtl/traf_phase_ctrl_rr_pick.sv
// traf_rr_pick: combinational round-robin next-phase search.
//   demand : per-phase demand vector
//   cur    : phase currently served
//   nxt    : first phase after cur (wrapping) with demand; cur+1 if none
module traf_rr_pick #(
    parameter int NUM_PHASES = 4
) (
    input  logic [NUM_PHASES-1:0]         demand,
    input  logic [$clog2(NUM_PHASES)-1:0] cur,
    output logic [$clog2(NUM_PHASES)-1:0] nxt
);
    localparam int PW = $clog2(NUM_PHASES);

    // Walk offsets from farthest to nearest so the nearest demanding phase
    // is the last (winning) assignment. The current phase itself is skipped.
    always_comb begin
        nxt = PW'((int'(cur) + 1) % NUM_PHASES);
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            if (demand[(int'(cur) + k) % NUM_PHASES])
                nxt = PW'((int'(cur) + k) % NUM_PHASES);
        end
    end

endmodule

// File: rtl/traf_phase_ctrl.sv
// traf_phase_ctrl: actuated traffic signal phase controller.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset (phase 0 green, demand cleared)
//   bus     : traf_phase_ctrl_if.slave (tick, sense in; lamps, phase, pending out)
// Optional feature: define TRAF_PED_EN to add pedestrian requests (bus.ped_req),
// walk lamps (bus.walk) and parameter WALK_T.
module traf_phase_ctrl
    import traf_pkg::*;
#(
    parameter int NUM_PHASES = NUM_PHASES_DEF,
    parameter int GREEN_MIN  = GREEN_MIN_DEF,
    parameter int GREEN_MAX  = GREEN_MAX_DEF,
    parameter int YELLOW_T   = YELLOW_T_DEF,
    parameter int ALL_RED_T  = ALL_RED_T_DEF
`ifdef TRAF_PED_EN
    ,
    parameter int WALK_T     = WALK_T_DEF
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    traf_phase_ctrl_if.slave   bus
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam int TW = TCNT_W;
    localparam logic [TW-1:0] GMIN_L = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_L = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YEL_L  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_L   = TW'(ALL_RED_T - 1);
    localparam logic [NUM_PHASES-1:0] ONE = NUM_PHASES'(1);

    state_e                state;
    logic [TW-1:0]         tcnt;
    logic [PW-1:0]         phase;
    logic [NUM_PHASES-1:0] pending;
    logic [NUM_PHASES-1:0] red, yellow, green;

    logic [NUM_PHASES-1:0] demand, others, req_set, clr_mask, oh_cur, oh_nxt;
    logic [PW-1:0]         nxt;
    logic                  leave_green, leave_yellow, leave_allred;

    assign demand = pending | bus.sense;

    always_comb begin
        others        = demand;
        others[phase] = 1'b0;
    end

    traf_rr_pick #(.NUM_PHASES(NUM_PHASES)) u_pick (
        .demand (demand),
        .cur    (phase),
        .nxt    (nxt)
    );

    assign oh_cur = ONE << phase;
    assign oh_nxt = ONE << nxt;

    // A phase that keeps its own detector busy may extend to GREEN_MAX.
    assign leave_green  = bus.tick && (state == GREEN) && (tcnt >= GMIN_L) && (|others)
                          && (!bus.sense[phase] || (tcnt >= GMAX_L));
    assign leave_yellow = bus.tick && (state == YELLOW)  && (tcnt == YEL_L);
    assign leave_allred = bus.tick && (state == ALL_RED) && (tcnt == AR_L);

    // The phase entering green has its demand consumed even if its detector
    // is still active that cycle.
    assign clr_mask = leave_allred ? oh_nxt : '0;

`ifdef TRAF_PED_EN
    assign req_set = bus.sense | bus.ped_req;
`else
    assign req_set = bus.sense;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= GREEN;
            tcnt    <= '0;
            phase   <= '0;
            pending <= '0;
            green   <= ONE;
            red     <= ~ONE;
            yellow  <= '0;
        end else begin
            pending <= (pending | req_set) & ~clr_mask;
            if (leave_green) begin
                state  <= YELLOW;
                tcnt   <= '0;
                green  <= '0;
                yellow <= oh_cur;
                red    <= ~oh_cur;
            end else if (leave_yellow) begin
                state  <= ALL_RED;
                tcnt   <= '0;
                yellow <= '0;
                red    <= '1;
            end else if (leave_allred) begin
                state  <= GREEN;
                tcnt   <= '0;
                phase  <= nxt;
                green  <= oh_nxt;
                red    <= ~oh_nxt;
            end else if (bus.tick && (state != GREEN || tcnt < GMAX_L)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign bus.red     = red;
    assign bus.yellow  = yellow;
    assign bus.green   = green;
    assign bus.phase   = phase;
    assign bus.pending = pending;

`ifdef TRAF_PED_EN
    localparam logic [TW-1:0] WALK_L = TW'(WALK_T - 1);

    // Pedestrian requests are tracked apart from vehicle demand so that walk
    // is only shown for a green that a pedestrian actually asked for.
    logic [NUM_PHASES-1:0] ped_lat;
    logic [NUM_PHASES-1:0] walk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_lat <= '0;
            walk    <= '0;
        end else begin
            ped_lat <= (ped_lat | bus.ped_req) & ~clr_mask;
            if (leave_allred)
                walk <= oh_nxt & (ped_lat | bus.ped_req);
            else if (leave_green || leave_yellow)
                walk <= '0;
            else if (bus.tick && state == GREEN && tcnt == WALK_L)
                walk <= '0;
        end
    end

    assign bus.walk = walk;
`endif

endmodule

// File: tb/tb_traf_phase_ctrl.sv
// Testbench for traf_phase_ctrl: directed stimulus pushes expected lamp/phase/
// pending snapshots (tagged with a cycle number) into a scoreboard queue; a
// monitor on the falling edge pops and compares the entries due that cycle.
module tb_traf_phase_ctrl;
    import traf_pkg::*;

    localparam int NP = 4;

    typedef struct packed {
        int         cyc;
        logic [3:0] red, yel, grn, pend, pmask, walk;
        logic [1:0] ph;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sbq[$];
    string nmq[$];
    exp_t mon_e;
    string mon_n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    traf_phase_ctrl_if #(.NUM_PHASES(NP)) bus ();

    traf_phase_ctrl #(
        .NUM_PHASES(NP), .GREEN_MIN(5), .GREEN_MAX(20), .YELLOW_T(3), .ALL_RED_T(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // st: 0 green, 1 yellow, 2 all-red; k is relative to base.
    task automatic expect_st(input int k, input string nm, input int st, input int ph,
                             input logic [3:0] pend, input logic [3:0] pmask,
                             input logic [3:0] walk = 4'b0000);
        exp_t e;
        logic [3:0] oh;
        oh = 4'b0000;
        oh[ph] = 1'b1;
        e.cyc = base + k;
        e.ph = 2'(ph);
        e.pend = pend;
        e.pmask = pmask;
        e.walk = walk;
        case (st)
            0:       begin e.grn = oh;    e.yel = 4'b0000; e.red = ~oh;    end
            1:       begin e.grn = 4'b0;  e.yel = oh;      e.red = ~oh;    end
            default: begin e.grn = 4'b0;  e.yel = 4'b0000; e.red = 4'hf;   end
        endcase
        sbq.push_back(e);
        nmq.push_back(nm);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Asserts reset mid-cycle with all detectors active (reset must still hold
    // pending at zero), then releases it; cycle 0 starts at release.
    task automatic go_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        bus.tick = 1'b0;
        bus.sense = 4'hf;
        base = cyc;
        expect_st(0, "reset_state", 0, 0, 4'h0, 4'hf);
        wait_cycles(2);
        bus.sense = 4'h0;
        reset_n = 1'b1;
        base = cyc;
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            mon_n = nmq.pop_front();
            n_chk++;
            if (mon_e.cyc < cyc) begin
                $display("FAIL %s: check missed, due cycle %0d now %0d", mon_n, mon_e.cyc, cyc);
            end else if (bus.red !== mon_e.red || bus.yellow !== mon_e.yel ||
                         bus.green !== mon_e.grn || bus.phase !== mon_e.ph ||
                         (bus.pending & mon_e.pmask) !== (mon_e.pend & mon_e.pmask)
`ifdef TRAF_PED_EN
                         || bus.walk !== mon_e.walk
`endif
                         ) begin
                $display("FAIL %s @%0d: got r=%b y=%b g=%b ph=%0d pend=%b, want r=%b y=%b g=%b ph=%0d pend=%b (mask %b)",
                         mon_n, cyc - base, bus.red, bus.yellow, bus.green, bus.phase, bus.pending,
                         mon_e.red, mon_e.yel, mon_e.grn, mon_e.ph, mon_e.pend, mon_e.pmask);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        bus.tick = 1'b0;
        bus.sense = 4'h0;
`ifdef TRAF_PED_EN
        bus.ped_req = 4'h0;
`endif

        // Single demand on phase 2.
        go_reset();
        bus.tick = 1'b1;
        bus.sense = 4'b0100;
        expect_st(0, "t1_c0", 0, 0, 4'h0, 4'hf);
        expect_st(4, "t1_green_end", 0, 0, 4'h4, 4'hf);
        expect_st(5, "t1_yellow_start", 1, 0, 4'h4, 4'hf);
        expect_st(7, "t1_yellow_end", 1, 0, 4'h4, 4'hf);
        expect_st(8, "t1_allred", 2, 0, 4'h4, 4'hf);
        expect_st(9, "t1_green_p2", 0, 2, 4'h0, 4'hf);
        expect_st(30, "t1_rest_p2", 0, 2, 4'h4, 4'hf);
        wait_cycles(31);

        // Own detector held: green extends to GREEN_MAX.
        go_reset();
        bus.tick = 1'b1;
        bus.sense = 4'b0011;
        expect_st(0, "t2_c0", 0, 0, 4'h0, 4'hf);
        expect_st(19, "t2_green_max", 0, 0, 4'h3, 4'hf);
        expect_st(20, "t2_yellow", 1, 0, 4'h3, 4'hf);
        expect_st(22, "t2_yellow_end", 1, 0, 4'h3, 4'hf);
        expect_st(23, "t2_allred", 2, 0, 4'h3, 4'hf);
        expect_st(24, "t2_green_p1", 0, 1, 4'h1, 4'hf);
        expect_st(43, "t2_p1_max", 0, 1, 4'h3, 4'hf);
        expect_st(44, "t2_p1_yellow", 1, 1, 4'h3, 4'hf);
        expect_st(48, "t2_wrap_p0", 0, 0, 4'h2, 4'hf);
        wait_cycles(50);

        // No demand: rest on phase 0.
        go_reset();
        bus.tick = 1'b1;
        for (int k = 0; k < 100; k += 11)
            expect_st(k, "t3_rest_p0", 0, 0, 4'h0, 4'hf);
        wait_cycles(100);

        // One-cycle pulses on phases 1 and 3.
        go_reset();
        bus.tick = 1'b1;
        expect_st(3, "t4_latched", 0, 0, 4'ha, 4'hf);
        expect_st(5, "t4_yellow_p0", 1, 0, 4'ha, 4'hf);
        expect_st(9, "t4_green_p1", 0, 1, 4'h8, 4'hf);
        expect_st(14, "t4_yellow_p1", 1, 1, 4'h8, 4'hf);
        expect_st(18, "t4_green_p3", 0, 3, 4'h0, 4'hf);
        expect_st(40, "t4_rest_p3", 0, 3, 4'h0, 4'hf);
        wait_cycles(2);
        bus.sense = 4'b1010;
        wait_cycles(1);
        bus.sense = 4'b0000;
        wait_cycles(40);

        // Tick every 4th cycle: all intervals x4.
        go_reset();
        bus.sense = 4'b0100;
        expect_st(19, "t5_green_x4", 0, 0, 4'h4, 4'hf);
        expect_st(20, "t5_yellow_x4", 1, 0, 4'h4, 4'hf);
        expect_st(31, "t5_yellow_end_x4", 1, 0, 4'h4, 4'hf);
        expect_st(32, "t5_allred_x4", 2, 0, 4'h4, 4'hf);
        expect_st(35, "t5_allred_end_x4", 2, 0, 4'h4, 4'hf);
        expect_st(36, "t5_green_p2_x4", 0, 2, 4'h0, 4'h4);
        for (int k = 0; k < 40; k++) begin
            bus.tick = (k % 4 == 3);
            wait_cycles(1);
        end

        // Reset during yellow: back to phase 0 green at once, no clearance.
        go_reset();
        bus.tick = 1'b1;
        bus.sense = 4'b0100;
        expect_st(5, "t6_yellow", 1, 0, 4'h4, 4'hf);
        wait_cycles(6);
        reset_n = 1'b0;
        expect_st(6, "t6_reset_mid_yellow", 0, 0, 4'h0, 4'hf);
        wait_cycles(1);
        reset_n = 1'b1;
        base = cyc;
        expect_st(0, "t6_post_c0", 0, 0, 4'h0, 4'hf);
        expect_st(4, "t6_post_green_end", 0, 0, 4'h4, 4'hf);
        expect_st(5, "t6_post_yellow", 1, 0, 4'h4, 4'hf);
        wait_cycles(8);

`ifdef TRAF_PED_EN
        // Pedestrian request on phase 2: walk for the first 4 ticks of its green.
        go_reset();
        bus.tick = 1'b1;
        bus.ped_req = 4'b0100;
        expect_st(1, "t7_ped_pending", 0, 0, 4'h4, 4'hf);
        expect_st(8, "t7_allred", 2, 0, 4'h4, 4'hf);
        expect_st(9, "t7_walk_on", 0, 2, 4'h0, 4'hf, 4'b0100);
        expect_st(12, "t7_walk_last", 0, 2, 4'h0, 4'hf, 4'b0100);
        expect_st(13, "t7_walk_off", 0, 2, 4'h0, 4'hf, 4'b0000);
        wait_cycles(1);
        bus.ped_req = 4'b0000;
        wait_cycles(15);
`endif

        for (int i = 0; i < 50 && sbq.size() > 0; i++) wait_cycles(1);
        if (sbq.size() > 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
